// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit sequencer driving an external PISO shift register.
// Frame = start bit, W_DATA data bits (LSB first), optional even-parity bit, stop bit.
// The optional parity bit is compiled in when the macro UART_TX_PARITY_EN is defined.
// Reset (rst) is synchronous and active-low.
module uart_tx_ctrl #(
    parameter int W_DATA       = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic tx_valid,
    output logic tx_ready,
    output logic piso_load,
    output logic piso_enb,
    input  logic piso_out,
    input  logic piso_parity,
    output logic tx,
    output logic busy,
    output logic tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (W_DATA > 1) ? $clog2(W_DATA) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W_DATA - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             bit_tick;

`ifndef UART_TX_PARITY_EN
    // Parity input stays on the port for pin compatibility but is not used.
    logic unused_parity;
    assign unused_parity = piso_parity;
`endif

    assign bit_tick = (cnt_reg == CNT_LAST);
    assign tx_ready = (state_reg == IDLE);
    assign busy     = (state_reg != IDLE);

    // State, baud counter and bit index registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
        end
    end

    // Next-state, counter and PISO/strobe outputs; everything is held off while reset is asserted.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        piso_load  = 1'b0;
        piso_enb   = 1'b0;
        tx_done    = 1'b0;

        // Baud counter runs in every non-idle state and wraps on each tick;
        // every state change coincides with a tick, so it also restarts there.
        if (state_reg == IDLE) begin
            cnt_next = '0;
        end else if (bit_tick) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (tx_valid) begin
                    piso_load  = 1'b1;
                    piso_enb   = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_next = DATA;
                    idx_next   = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    // One shift per data bit; W_DATA shifts rotate the PISO back to the loaded byte.
                    piso_enb = 1'b1;
                    idx_next = idx_reg + 1'b1;
                    if (idx_reg == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    tx_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                idx_next   = '0;
            end
        endcase

        // A handshake or shift coinciding with reset is discarded, and an aborted frame never reports done.
        if (!rst) begin
            piso_load = 1'b0;
            piso_enb  = 1'b0;
            tx_done   = 1'b0;
        end
    end

    // Serial line decoded from the registered state.
    always_comb begin
        tx = 1'b1;
        case (state_reg)
            IDLE:    tx = 1'b1;
            START:   tx = 1'b0;
            DATA:    tx = piso_out;
`ifdef UART_TX_PARITY_EN
            PARITY:  tx = piso_parity;
`endif
            STOP:    tx = 1'b1;
            default: tx = 1'b1;
        endcase
    end

endmodule
